// File: rtl/core_mc_if.sv
// Fetch and data-memory handshake bundle for core_mc.
// The core drives the master modport and the memory system drives the slave modport.
interface core_mc_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              instr_req;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_valid;
  logic [31:0]       instr_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ready;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output instr_req, instr_addr, mem_req, mem_we, mem_addr, mem_wdata,
    input  instr_valid, instr_data, mem_ready, mem_rdata
  );

  modport slave (
    input  instr_req, instr_addr, mem_req, mem_we, mem_addr, mem_wdata,
    output instr_valid, instr_data, mem_ready, mem_rdata
  );
endinterface

// File: rtl/core_mc.sv
// Multi-cycle RV32I-subset core: FETCH -> EXEC -> (MEM) with handshaked memories and sticky HALT.
// Defining CORE_PERF_EN builds the cycle/instret counters; otherwise they read 0.
module core_mc #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int RESET_PC = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] last_pc_i,
  core_mc_if.master         bus,
  output logic              retire_o,
  output logic              halted_o,
  output logic              err_o,
  output logic [31:0]       cycle_cnt_o,
  output logic [31:0]       instret_cnt_o
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [6:0] OP_LUI = 7'h37, OP_JAL = 7'h6F, OP_JALR = 7'h67, OP_BR  = 7'h63,
                         OP_LD  = 7'h03, OP_ST  = 7'h23, OP_IMM  = 7'h13, OP_REG = 7'h33;

  typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1, S_MEM = 2'd2, S_HALT = 2'd3} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q, mem_addr_q;
  logic [31:0]       instr_q;
  logic [XLEN-1:0]   mem_wdata_q;
  logic              mem_we_q, err_q;
  logic [XLEN-1:0]   rf_q [32];

  logic [6:0]         opcode_s;
  logic [4:0]         rd_s, rs1_s, rs2_s;
  logic [2:0]         f3_s, alu_f3_s;
  logic signed [31:0] imm32_s;
  logic [XLEN-1:0]    imm_s, rs1_v_s, rs2_v_s, op_b_s, alu_s, wb_s, link_s, rf_wd_s;
  logic [ADDR_W-1:0]  pc_inc_s, npc_s;
  logic               legal_s, is_mem_s, taken_s, alt_s, halt_now_s, rf_we_s;

  function automatic logic [XLEN-1:0] alu_f(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                            input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_f = alt ? (a - b) : (a + b);
      3'd1:    alu_f = a << b[SHW-1:0];
      3'd2:    alu_f = XLEN'($signed(a) < $signed(b));
      3'd3:    alu_f = XLEN'(a < b);
      3'd4:    alu_f = a ^ b;
      3'd5:    alu_f = alt ? XLEN'($signed(a) >>> b[SHW-1:0]) : (a >> b[SHW-1:0]);
      3'd6:    alu_f = a | b;
      3'd7:    alu_f = a & b;
      default: alu_f = '0;
    endcase
  endfunction

  assign opcode_s   = instr_q[6:0];
  assign rd_s       = instr_q[11:7];
  assign f3_s       = instr_q[14:12];
  assign rs1_s      = instr_q[19:15];
  assign rs2_s      = instr_q[24:20];
  assign rs1_v_s    = (rs1_s == 5'd0) ? '0 : rf_q[rs1_s];
  assign rs2_v_s    = (rs2_s == 5'd0) ? '0 : rf_q[rs2_s];
  assign imm_s      = XLEN'(imm32_s);
  assign is_mem_s   = (opcode_s == OP_LD) || (opcode_s == OP_ST);
  assign op_b_s     = (opcode_s == OP_REG || opcode_s == OP_BR) ? rs2_v_s : imm_s;
  assign alt_s      = (opcode_s == OP_REG || (opcode_s == OP_IMM && f3_s == 3'd5)) ? instr_q[30] : 1'b0;
  assign alu_f3_s   = (opcode_s == OP_REG || opcode_s == OP_IMM) ? f3_s : 3'd0;
  assign alu_s      = alu_f(rs1_v_s, op_b_s, alu_f3_s, alt_s);
  assign pc_inc_s   = pc_q + ADDR_W'(1);
  assign link_s     = XLEN'(pc_inc_s) << 2;
  assign halt_now_s = (pc_q == last_pc_i);

  // Immediate extraction per format; unknown opcodes are flagged illegal.
  always_comb begin
    imm32_s = 32'sd0;
    legal_s = 1'b1;
    case (opcode_s)
      OP_IMM, OP_JALR, OP_LD: imm32_s = $signed({{20{instr_q[31]}}, instr_q[31:20]});
      OP_ST:   imm32_s = $signed({{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]});
      OP_BR:   imm32_s = $signed({{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                                  instr_q[11:8], 1'b0});
      OP_JAL:  imm32_s = $signed({{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                                  instr_q[30:21], 1'b0});
      OP_LUI:  imm32_s = $signed({instr_q[31:12], 12'h000});
      OP_REG:  imm32_s = 32'sd0;
      default: legal_s = 1'b0;
    endcase
  end

  // Branch condition evaluation.
  always_comb begin
    taken_s = 1'b0;
    if (opcode_s == OP_BR) begin
      case (f3_s)
        3'd0:    taken_s = (rs1_v_s == rs2_v_s);
        3'd1:    taken_s = (rs1_v_s != rs2_v_s);
        3'd4:    taken_s = ($signed(rs1_v_s) < $signed(rs2_v_s));
        3'd5:    taken_s = ($signed(rs1_v_s) >= $signed(rs2_v_s));
        3'd6:    taken_s = (rs1_v_s < rs2_v_s);
        3'd7:    taken_s = (rs1_v_s >= rs2_v_s);
        default: taken_s = 1'b0;
      endcase
    end else begin
      taken_s = 1'b0;
    end
  end

  // Next pc (word address) and register write-back value.
  always_comb begin
    npc_s = pc_inc_s;
    wb_s  = alu_s;
    if (opcode_s == OP_JAL || taken_s) begin
      npc_s = pc_q + ADDR_W'($signed(imm_s) >>> 2);
    end else if (opcode_s == OP_JALR) begin
      npc_s = ADDR_W'(alu_s >> 2);
    end else begin
      npc_s = pc_inc_s;
    end
    if (opcode_s == OP_LUI) begin
      wb_s = imm_s;
    end else if (opcode_s == OP_JAL || opcode_s == OP_JALR) begin
      wb_s = link_s;
    end else begin
      wb_s = alu_s;
    end
  end

  assign rf_we_s  = (state_q == S_EXEC && legal_s && !is_mem_s && opcode_s != OP_BR) ||
                    (state_q == S_MEM && bus.mem_ready && !mem_we_q);
  assign rf_wd_s  = (state_q == S_MEM) ? bus.mem_rdata : wb_s;
  assign retire_o = (state_q == S_EXEC && legal_s && !is_mem_s) ||
                    (state_q == S_MEM && bus.mem_ready);

  // Register file; x0 is never written and reads as zero.
  always_ff @(posedge clk_i) begin
    if (!rst_i && rf_we_s && rd_s != 5'd0) begin
      rf_q[rd_s] <= rf_wd_s;
    end
  end

  // Control FSM; memory address/data are captured in EXEC so they hold steady through MEM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_FETCH;
      pc_q        <= ADDR_W'(RESET_PC);
      instr_q     <= 32'h0000_0000;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (bus.instr_valid) begin
            instr_q <= bus.instr_data;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!legal_s) begin
            err_q   <= 1'b1;
            state_q <= S_HALT;
          end else if (is_mem_s) begin
            mem_we_q    <= (opcode_s == OP_ST);
            mem_addr_q  <= ADDR_W'(alu_s >> 2);
            mem_wdata_q <= rs2_v_s;
            state_q     <= S_MEM;
          end else begin
            pc_q    <= npc_s;
            state_q <= halt_now_s ? S_HALT : S_FETCH;
          end
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            pc_q    <= npc_s;
            state_q <= halt_now_s ? S_HALT : S_FETCH;
          end
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_HALT;
      endcase
    end
  end

  assign bus.instr_req  = (state_q == S_FETCH);
  assign bus.instr_addr = pc_q;
  assign bus.mem_req    = (state_q == S_MEM);
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign halted_o       = (state_q == S_HALT);
  assign err_o          = err_q;

`ifdef CORE_PERF_EN
  logic [31:0] cycle_q, instret_q;

  // Free-running cycle and retired-instruction counters, wrapping at 2^32.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_q   <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      cycle_q   <= cycle_q + 32'd1;
      instret_q <= retire_o ? (instret_q + 32'd1) : instret_q;
    end
  end

  assign cycle_cnt_o   = cycle_q;
  assign instret_cnt_o = instret_q;
`else
  assign cycle_cnt_o   = 32'd0;
  assign instret_cnt_o = 32'd0;
`endif
endmodule

// File: tb/tb_core_mc.sv
// Directed bench for core_mc: a table of instructions served through the handshake ports
// plus hand-written sequences for halt, illegal opcode and reset during MEM.
module tb_core_mc;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] last_pc;
  logic        retire, halted, err;
  logic [31:0] cycle_cnt, instret_cnt;
  int          checks = 0;
  int          failures = 0;
  int          ret_cnt = 0;
  int          cyc_model = 0;
  int          excl_bad = 0;
  int          base;

  typedef struct {
    logic [31:0] instr;
    int          iwait;
    int          mwait;
    logic [31:0] rdata;
    logic [31:0] exp_pc;
    int          kind;      // 0 = no memory access, 1 = load, 2 = store
    logic [31:0] exp_maddr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [20];

  core_mc_if #(.XLEN(32), .ADDR_W(32)) bus_if ();

  core_mc #(.XLEN(32), .ADDR_W(32), .RESET_PC(0)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .last_pc_i     (last_pc),
    .bus           (bus_if.master),
    .retire_o      (retire),
    .halted_o      (halted),
    .err_o         (err),
    .cycle_cnt_o   (cycle_cnt),
    .instret_cnt_o (instret_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc_model <= 0;
    else cyc_model <= cyc_model + 1;
    if (!rst && retire) ret_cnt <= ret_cnt + 1;
  end

  always @(negedge clk) begin
    if (!rst && bus_if.instr_req && bus_if.mem_req) excl_bad <= excl_bad + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000, expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first cycle after rst falls.
  task automatic do_reset(input logic [31:0] lp);
    rst = 1'b1;
    last_pc = lp;
    bus_if.instr_valid = 1'b0;
    bus_if.mem_ready = 1'b0;
    step();
    step();
    check("rst mem_req", {31'd0, bus_if.mem_req}, 32'd0);
    check("rst retire", {31'd0, retire}, 32'd0);
    check("rst halted", {31'd0, halted}, 32'd0);
    check("rst err", {31'd0, err}, 32'd0);
    check("rst cycle_cnt", cycle_cnt, 32'd0);
    check("rst instret_cnt", instret_cnt, 32'd0);
    rst = 1'b0;
    check("post-rst instr_req", {31'd0, bus_if.instr_req}, 32'd1);
    check("post-rst instr_addr", bus_if.instr_addr, 32'd0);
  endtask

  task automatic check_mem(input int i);
    check($sformatf("v%0d mem_req", i), {31'd0, bus_if.mem_req}, 32'd1);
    check($sformatf("v%0d instr_req in MEM", i), {31'd0, bus_if.instr_req}, 32'd0);
    check($sformatf("v%0d mem_we", i), {31'd0, bus_if.mem_we}, (vecs[i].kind == 2) ? 32'd1 : 32'd0);
    check($sformatf("v%0d mem_addr", i), bus_if.mem_addr, vecs[i].exp_maddr);
    if (vecs[i].kind == 2) check($sformatf("v%0d mem_wdata", i), bus_if.mem_wdata, vecs[i].exp_wdata);
  endtask

  initial begin
    vecs[0]  = '{32'h00500093, 0, 0, 32'h0, 32'd0,  0, 32'd0, 32'h0};        // addi x1,x0,5
    vecs[1]  = '{32'h00308113, 0, 0, 32'h0, 32'd1,  0, 32'd0, 32'h0};        // addi x2,x1,3
    vecs[2]  = '{32'h00202423, 0, 2, 32'h0, 32'd2,  2, 32'd2, 32'd8};        // sw x2,8(x0)
    vecs[3]  = '{32'h00802183, 0, 2, 32'd8, 32'd3,  1, 32'd2, 32'h0};        // lw x3,8(x0)
    vecs[4]  = '{32'hFE000CE3, 0, 0, 32'h0, 32'd4,  0, 32'd0, 32'h0};        // beq x0,x0,-8
    vecs[5]  = '{32'h00302623, 0, 0, 32'h0, 32'd2,  2, 32'd3, 32'd8};        // sw x3,12(x0)
    vecs[6]  = '{32'h00C000EF, 0, 0, 32'h0, 32'd3,  0, 32'd0, 32'h0};        // jal x1,+12
    vecs[7]  = '{32'h00001463, 0, 0, 32'h0, 32'd6,  0, 32'd0, 32'h0};        // bne x0,x0,+8
    vecs[8]  = '{32'h00102023, 0, 0, 32'h0, 32'd7,  2, 32'd0, 32'd16};       // sw x1,0(x0)
    vecs[9]  = '{32'h00208233, 0, 0, 32'h0, 32'd8,  0, 32'd0, 32'h0};        // add x4,x1,x2
    vecs[10] = '{32'h403202B3, 0, 0, 32'h0, 32'd9,  0, 32'd0, 32'h0};        // sub x5,x4,x3
    vecs[11] = '{32'h00502223, 0, 0, 32'h0, 32'd10, 2, 32'd1, 32'd16};       // sw x5,4(x0)
    vecs[12] = '{32'h00700013, 0, 0, 32'h0, 32'd11, 0, 32'd0, 32'h0};        // addi x0,x0,7
    vecs[13] = '{32'h00002023, 0, 0, 32'h0, 32'd12, 2, 32'd0, 32'd0};        // sw x0,0(x0)
    vecs[14] = '{32'h00808367, 0, 0, 32'h0, 32'd13, 0, 32'd0, 32'h0};        // jalr x6,x1,8
    vecs[15] = '{32'h00602823, 0, 0, 32'h0, 32'd6,  2, 32'd4, 32'd56};       // sw x6,16(x0)
    vecs[16] = '{32'h123453B7, 0, 0, 32'h0, 32'd7,  0, 32'd0, 32'h0};        // lui x7,0x12345
    vecs[17] = '{32'h00702A23, 0, 0, 32'h0, 32'd8,  2, 32'd5, 32'h12345000}; // sw x7,20(x0)
    vecs[18] = '{32'hFFF00413, 3, 0, 32'h0, 32'd9,  0, 32'd0, 32'h0};        // addi x8,x0,-1
    vecs[19] = '{32'h00802C23, 0, 1, 32'h0, 32'd10, 2, 32'd6, 32'hFFFFFFFF}; // sw x8,24(x0)

    rst = 1'b1;
    last_pc = 32'd0;
    bus_if.instr_valid = 1'b0;
    bus_if.instr_data = 32'h0;
    bus_if.mem_ready = 1'b0;
    bus_if.mem_rdata = 32'h0;

    // Two addi with zero-wait fetch, halting after pc 1; cycle 1 is the first after reset.
    do_reset(32'd1);
    base = ret_cnt;
    bus_if.instr_valid = 1'b1;
    bus_if.instr_data = 32'h00500093;
    step();
    bus_if.instr_valid = 1'b0;
    check("t1 retire c2", {31'd0, retire}, 32'd1);
    check("t1 halted c2", {31'd0, halted}, 32'd0);
    step();
    check("t1 retire c3", {31'd0, retire}, 32'd0);
    check("t1 fetch addr c3", bus_if.instr_addr, 32'd1);
    bus_if.instr_valid = 1'b1;
    bus_if.instr_data = 32'h00308113;
    step();
    bus_if.instr_valid = 1'b0;
    check("t1 retire c4", {31'd0, retire}, 32'd1);
    check("t1 halted c4", {31'd0, halted}, 32'd0);
    step();
    check("t1 halted c5", {31'd0, halted}, 32'd1);
    check("t1 err c5", {31'd0, err}, 32'd0);
    check("t1 retire c5", {31'd0, retire}, 32'd0);
    repeat (3) step();
    check("t1 halt no instr_req", {31'd0, bus_if.instr_req}, 32'd0);
    check("t1 halt no mem_req", {31'd0, bus_if.mem_req}, 32'd0);
    check("t1 halted sticky", {31'd0, halted}, 32'd1);
    check("t1 retire count", 32'(ret_cnt - base), 32'd2);
`ifdef CORE_PERF_EN
    check("t1 instret_cnt", instret_cnt, 32'd2);
    check("t1 cycle_cnt", cycle_cnt, 32'(cyc_model));
    check("t1 cycle_cnt value", cycle_cnt, 32'd7);
`else
    check("t1 instret_cnt off", instret_cnt, 32'd0);
    check("t1 cycle_cnt off", cycle_cnt, 32'd0);
`endif

    // Instruction table with fetch and data wait states.
    do_reset(32'hFFFF_FFFF);
    base = ret_cnt;
    for (int i = 0; i < 20; i++) begin
      for (int n = 0; n < 20 && !bus_if.instr_req; n++) step();
      check($sformatf("v%0d instr_req", i), {31'd0, bus_if.instr_req}, 32'd1);
      check($sformatf("v%0d instr_addr", i), bus_if.instr_addr, vecs[i].exp_pc);
      for (int k = 0; k < vecs[i].iwait; k++) begin
        bus_if.instr_valid = 1'b0;
        step();
        check($sformatf("v%0d held instr_req", i), {31'd0, bus_if.instr_req}, 32'd1);
        check($sformatf("v%0d held instr_addr", i), bus_if.instr_addr, vecs[i].exp_pc);
      end
      bus_if.instr_valid = 1'b1;
      bus_if.instr_data = vecs[i].instr;
      step();
      bus_if.instr_valid = 1'b0;
      if (vecs[i].kind == 0) begin
        check($sformatf("v%0d retire", i), {31'd0, retire}, 32'd1);
        step();
      end else begin
        check($sformatf("v%0d no retire in EXEC", i), {31'd0, retire}, 32'd0);
        step();
        check_mem(i);
        for (int k = 0; k < vecs[i].mwait; k++) begin
          bus_if.mem_ready = 1'b0;
          step();
          check_mem(i);
        end
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = vecs[i].rdata;
        #1;
        check($sformatf("v%0d mem retire", i), {31'd0, retire}, 32'd1);
        step();
        bus_if.mem_ready = 1'b0;
      end
    end
    check("table retire count", 32'(ret_cnt - base), 32'd20);
`ifdef CORE_PERF_EN
    check("table instret_cnt", instret_cnt, 32'd20);
    check("table cycle_cnt", cycle_cnt, 32'(cyc_model));
`endif

    // Halt after a store retires at last_pc.
    do_reset(32'd0);
    bus_if.instr_valid = 1'b1;
    bus_if.instr_data = 32'h00002023;
    step();
    bus_if.instr_valid = 1'b0;
    step();
    check("st-halt mem_req", {31'd0, bus_if.mem_req}, 32'd1);
    bus_if.mem_ready = 1'b1;
    #1;
    check("st-halt retire", {31'd0, retire}, 32'd1);
    step();
    bus_if.mem_ready = 1'b0;
    check("st-halt halted", {31'd0, halted}, 32'd1);
    check("st-halt mem_req off", {31'd0, bus_if.mem_req}, 32'd0);
    check("st-halt instr_req off", {31'd0, bus_if.instr_req}, 32'd0);

    // Illegal opcode: halt with err, no retire, no requests.
    do_reset(32'hFFFF_FFFF);
    base = ret_cnt;
    bus_if.instr_valid = 1'b1;
    bus_if.instr_data = 32'h0000007F;
    step();
    bus_if.instr_valid = 1'b0;
    check("ill retire", {31'd0, retire}, 32'd0);
    step();
    check("ill halted", {31'd0, halted}, 32'd1);
    check("ill err", {31'd0, err}, 32'd1);
    repeat (4) step();
    check("ill no instr_req", {31'd0, bus_if.instr_req}, 32'd0);
    check("ill no mem_req", {31'd0, bus_if.mem_req}, 32'd0);
    check("ill err sticky", {31'd0, err}, 32'd1);
    check("ill retire count", 32'(ret_cnt - base), 32'd0);

    // Reset pulse while a store waits in MEM.
    do_reset(32'hFFFF_FFFF);
    bus_if.instr_valid = 1'b1;
    bus_if.instr_data = 32'h00500093;
    step();
    bus_if.instr_valid = 1'b0;
    step();
    check("rm fetch addr", bus_if.instr_addr, 32'd1);
    bus_if.instr_valid = 1'b1;
    bus_if.instr_data = 32'h00002023;
    step();
    bus_if.instr_valid = 1'b0;
    step();
    check("rm mem_req before rst", {31'd0, bus_if.mem_req}, 32'd1);
    rst = 1'b1;
    step();
    check("rm mem_req after rst", {31'd0, bus_if.mem_req}, 32'd0);
    check("rm pc after rst", bus_if.instr_addr, 32'd0);
    rst = 1'b0;
    check("rm instr_req restart", {31'd0, bus_if.instr_req}, 32'd1);
    check("rm instr_addr restart", bus_if.instr_addr, 32'd0);
    bus_if.instr_valid = 1'b1;
    bus_if.instr_data = 32'h00500093;
    step();
    bus_if.instr_valid = 1'b0;
    check("rm retire after restart", {31'd0, retire}, 32'd1);
    step();
    check("rm next fetch addr", bus_if.instr_addr, 32'd1);

    check("req exclusive", 32'(excl_bad), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
